// File: rtl/dec_scan_if.sv
// dec_scan select handshake: sel qualified by sel_valid, accepted on sel_ready.
// master drives sel/sel_valid, slave (dec_scan) returns sel_ready.
interface dec_scan_if #(
  parameter int SEL_W = 4
);
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             sel_ready;

  modport master (
    output sel,
    output sel_valid,
    input  sel_ready
  );

  modport slave (
    input  sel,
    input  sel_valid,
    output sel_ready
  );
endinterface

// File: rtl/dec_scan.sv
// dec_scan: registered one-hot decoder with direct-select and auto-scan modes.
// Ports: clk, rst_n (async low), en, mode (0 direct / 1 scan),
//   bus (sel/sel_valid/sel_ready), y one-hot, idx driven index, step pulse.
// Macro DEC_SCAN_BLANK_EN adds one all-zero BLANK cycle between scan slots.
module dec_scan #(
  parameter  int SEL_W = 4,
  parameter  int DWELL = 4,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  dec_scan_if.slave        bus,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             step
);

`ifdef DEC_SCAN_BLANK_EN
  typedef enum logic [1:0] {
    IDLE, DIRECT, SCAN, BLANK
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, DIRECT, SCAN
  } state_t;
`endif

  state_t     state;
  logic [7:0] cnt;
  logic       ready;
  logic [SEL_W-1:0] nxt;

  function automatic logic [OUT_W-1:0] onehot(
    input logic [SEL_W-1:0] s
  );
    onehot    = '0;
    onehot[s] = 1'b1;
  endfunction

  // rst_n gates ready so nothing is accepted while in reset
`ifdef DEC_SCAN_BLANK_EN
  assign ready = rst_n & en & ~mode
               & (state != BLANK);
`else
  assign ready = rst_n & en & ~mode;
`endif

  assign bus.sel_ready = ready;

  // OUT_W is a power of two, so the add wraps
  assign nxt = idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= '0;
      idx   <= '0;
      step  <= 1'b0;
      cnt   <= '0;
    end else if (!en) begin
      state <= IDLE;
      y     <= '0;
      idx   <= '0;
      step  <= 1'b0;
      cnt   <= '0;
    end else if (!mode) begin
      step <= 1'b0;
      cnt  <= '0;
      if (bus.sel_valid && ready) begin
        state <= DIRECT;
        y     <= onehot(bus.sel);
        idx   <= bus.sel;
      end else if (state != DIRECT) begin
        // leaving scan (or idling): outputs go dark
        state <= IDLE;
        y     <= '0;
        idx   <= '0;
      end
    end else begin
      unique case (state)
        SCAN: begin
          if (cnt == 8'(DWELL - 1)) begin
            cnt <= '0;
`ifdef DEC_SCAN_BLANK_EN
            state <= BLANK;
            y     <= '0;
            step  <= 1'b0;
`else
            idx   <= nxt;
            y     <= onehot(nxt);
            step  <= 1'b1;
`endif
          end else begin
            cnt  <= cnt + 8'd1;
            step <= 1'b0;
          end
        end
`ifdef DEC_SCAN_BLANK_EN
        BLANK: begin
          // step marks the first cycle of the new index
          state <= SCAN;
          idx   <= nxt;
          y     <= onehot(nxt);
          step  <= 1'b1;
          cnt   <= '0;
        end
`endif
        default: begin
          state <= SCAN;
          idx   <= '0;
          y     <= onehot('0);
          step  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_scan.sv
// tb_dec_scan: randomized self-checking bench for dec_scan.
// Scan model is slot/phase arithmetic over cycles since scan entry.
module tb_dec_scan;
  localparam int SEL_W = 4;
  localparam int OUT_W = 2**SEL_W;
  localparam int DWELL = 4;
`ifdef DEC_SCAN_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif
  localparam int P = DWELL + BLK;
  localparam int W = OUT_W + SEL_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic [OUT_W-1:0] y, y1;
  logic [SEL_W-1:0] idx, idx1;
  logic step, step1;
  logic [W-1:0] got, ex;
  int errors = 0;
  int checks = 0;

  dec_scan_if #(.SEL_W(SEL_W)) bus ();
  dec_scan_if #(.SEL_W(SEL_W)) bus1 ();

  dec_scan #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .bus(bus), .y(y), .idx(idx), .step(step)
  );

  dec_scan #(.SEL_W(SEL_W), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .bus(bus1), .y(y1), .idx(idx1), .step(step1)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OUT_W-1:0] onehot(input int s);
    logic [OUT_W-1:0] r;
    r = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  // expected {y,idx,step} k cycles after scan entry, for a given dwell
  function automatic logic [W-1:0] scan_exp(input int k, input int dw);
    int p, slot, ph;
    logic [SEL_W-1:0] i;
    logic [OUT_W-1:0] yy;
    logic st;
    p    = dw + BLK;
    slot = k / p;
    ph   = k % p;
    i    = SEL_W'(slot % OUT_W);
    yy   = (BLK == 1 && ph == dw) ? '0 : onehot(int'(i));
    st   = (k > 0 && ph == 0);
    return {yy, i, st};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0;
    bus.sel = 4'd3; bus.sel_valid = 1'b1;
    bus1.sel = '0; bus1.sel_valid = 1'b0;
    repeat (2) cyc();
    checks++;
    if ({y, idx, step, bus.sel_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h ready=%b exp=0",
               {y, idx, step}, bus.sel_ready);
    end
    bus.sel_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({y, idx, step} !== '0 || bus.sel_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got=%h ready=%b exp=0 ready=1",
               {y, idx, step}, bus.sel_ready);
    end
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0;
    for (int s = 0; s < OUT_W; s++) begin
      bus.sel = SEL_W'(s); bus.sel_valid = 1'b1;
      #1;
      checks++;
      if (bus.sel_ready !== 1'b1) begin
        errors++;
        $display("FAIL direct_ready sel=%0d got=%b exp=1", s, bus.sel_ready);
      end
      cyc();
      ex = {onehot(s), SEL_W'(s), 1'b0};
      got = {y, idx, step};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL direct_xfer sel=%0d got=%h exp=%h", s, got, ex);
      end
      bus.sel_valid = 1'b0; bus.sel = SEL_W'($urandom);
      repeat ($urandom_range(1, 3)) begin
        cyc();
        got = {y, idx, step};
        checks++;
        if (got !== ex) begin
          errors++;
          $display("FAIL direct_hold sel=%0d got=%h exp=%h", s, got, ex);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int last;
    last = int'(idx);
    en = 1'b1; mode = 1'b0;
    for (int c = 0; c < 50; c++) begin
      bus.sel = SEL_W'($urandom);
      bus.sel_valid = (c < 20) ? 1'b1 : 1'($urandom);
      if (bus.sel_valid) last = int'(bus.sel);
      cyc();
      ex = {onehot(last), SEL_W'(last), 1'b0};
      got = {y, idx, step};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL b2b c=%0d got=%h exp=%h", c, got, ex);
      end
    end
    bus.sel_valid = 1'b0;
  endtask

  task automatic test_mode_wins();
    bus.sel = 4'd5; bus.sel_valid = 1'b1; mode = 1'b1;
    #1;
    checks++;
    if (bus.sel_ready !== 1'b0) begin
      errors++;
      $display("FAIL mode_wins_ready got=%b exp=0", bus.sel_ready);
    end
    cyc();
    ex = scan_exp(0, DWELL);
    got = {y, idx, step};
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL mode_wins got=%h exp=%h", got, ex);
    end
    bus.sel_valid = 1'b0; mode = 1'b0;
    cyc();
    checks++;
    if ({y, idx, step} !== '0) begin
      errors++;
      $display("FAIL scan_exit got=%h exp=0", {y, idx, step});
    end
  endtask

  task automatic test_scan();
    int nstep;
    mode = 1'b0; bus.sel = SEL_W'($urandom); bus.sel_valid = 1'b1;
    cyc();
    mode = 1'b1;
    nstep = 0;
    for (int k = 0; k < OUT_W * P + 6; k++) begin
      bus.sel = SEL_W'($urandom); bus.sel_valid = 1'($urandom);
      cyc();
      ex = scan_exp(k, DWELL);
      got = {y, idx, step};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL scan k=%0d got=%h exp=%h", k, got, ex);
      end
      ex = scan_exp(k, 1);
      got = {y1, idx1, step1};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL scan_dwell1 k=%0d got=%h exp=%h", k, got, ex);
      end
      if (k >= 1 && k <= OUT_W * P && step) nstep++;
    end
    checks++;
    if (nstep != OUT_W) begin
      errors++;
      $display("FAIL scan_steps got=%0d exp=%0d", nstep, OUT_W);
    end
  endtask

  task automatic test_mode_drop();
    int s;
    mode = 1'b0; bus.sel_valid = 1'b0;
    repeat (2) begin
      cyc();
      checks++;
      if ({y, idx, step} !== '0) begin
        errors++;
        $display("FAIL mode_drop got=%h exp=0", {y, idx, step});
      end
    end
    mode = 1'b1;
    repeat (3) cyc();
    s = int'($urandom_range(1, OUT_W - 1));
    mode = 1'b0; bus.sel = SEL_W'(s); bus.sel_valid = 1'b1;
    cyc();
    bus.sel_valid = 1'b0;
    ex = {onehot(s), SEL_W'(s), 1'b0};
    got = {y, idx, step};
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL mode_drop_xfer got=%h exp=%h", got, ex);
    end
  endtask

  task automatic test_reset_mid_scan();
    mode = 1'b1;
    for (int k = 0; k <= 9 * P + 1; k++) cyc();
    checks++;
    if (idx !== 4'd9) begin
      errors++;
      $display("FAIL rst_pre_idx got=%0d exp=9", idx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({y, idx, step} !== '0 || bus.sel_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got=%h ready=%b exp=0",
               {y, idx, step}, bus.sel_ready);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 2 * P + 3; k++) begin
      cyc();
      ex = scan_exp(k, DWELL);
      got = {y, idx, step};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL rst_resume k=%0d got=%h exp=%h", k, got, ex);
      end
    end
  endtask

  task automatic test_en_drop();
    mode = 1'b0; bus.sel = 4'd7; bus.sel_valid = 1'b1;
    cyc();
    checks++;
    if (y !== 16'h0080) begin
      errors++;
      $display("FAIL en_pre_y got=%h exp=0080", y);
    end
    en = 1'b0; bus.sel = SEL_W'($urandom);
    cyc();
    checks++;
    if ({y, idx, step} !== '0 || bus.sel_ready !== 1'b0) begin
      errors++;
      $display("FAIL en_drop got=%h ready=%b exp=0 ready=0",
               {y, idx, step}, bus.sel_ready);
    end
    en = 1'b1; mode = 1'b1; bus.sel_valid = 1'b0;
    repeat (DWELL + 2) cyc();
    en = 1'b0;
    cyc();
    checks++;
    if ({y, idx, step} !== '0) begin
      errors++;
      $display("FAIL en_drop_scan got=%h exp=0", {y, idx, step});
    end
    en = 1'b1; mode = 1'b0;
  endtask

  initial begin
    bus.sel = '0; bus.sel_valid = 1'b0;
    #2;
    test_reset();
    test_direct();
    test_back_to_back();
    test_mode_wins();
    test_scan();
    test_mode_drop();
    test_reset_mid_scan();
    test_en_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
